// File: rtl/access_pkg.sv
// Shared state codes and status-lamp colours for the gate access controller.
// PROG is only reachable when ACCESS_PROG_EN is defined.
package access_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        GRANTED = 3'd3,
        DENIED  = 3'd4,
        LOCK    = 3'd5,
        PROG    = 3'd6
    } state_t;

    localparam logic [2:0] RGB_IDLE  = 3'b001;
    localparam logic [2:0] RGB_ENTRY = 3'b011;
    localparam logic [2:0] RGB_OPEN  = 3'b010;
    localparam logic [2:0] RGB_DENY  = 3'b100;
    localparam logic [2:0] RGB_PROG  = 3'b111;
    localparam logic [2:0] RGB_OFF   = 3'b000;

    function automatic logic [2:0] state_rgb(state_t s, logic blink);
        logic [2:0] c;
        c = RGB_IDLE;
        case (s)
            IDLE:    c = RGB_IDLE;
            ENTRY:   c = RGB_ENTRY;
            CHECK:   c = RGB_ENTRY;
            GRANTED: c = RGB_OPEN;
            DENIED:  c = RGB_DENY;
            LOCK:    c = blink ? RGB_DENY : RGB_OFF;
            PROG:    c = RGB_PROG;
            default: c = RGB_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/access_ctrl_n_debounce.sv
// One keypad button: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted released-to-pressed change.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic bot,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    // raw input is active-low; lvl holds the debounced "pressed" level
    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lvl   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= bot;
            s2    <= s1;
            press <= 1'b0;
            if (~s2 != lvl) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    lvl   <= ~s2;
                    cnt   <= '0;
                    press <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/access_ctrl_n.sv
// Gate access controller: debounced keypad code entry, timed open window,
// try budget and lockout. Define ACCESS_PROG_EN for in-field reprogramming.
module access_ctrl_n
    import access_pkg::*;
#(
    parameter int NBTN       = 4,
    parameter int SYM_W      = 2,
    parameter int CODE_LEN   = 4,
    parameter logic [CODE_LEN*SYM_W-1:0] DEFAULT_CODE = 8'b11_10_01_00,
    parameter int MAX_TRIES  = 3,
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int OPEN_T     = 5,
    parameter int DENY_T     = 2,
    parameter int LOCK_T     = 20,
    parameter int ENTRY_TO   = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NBTN-1:0] bot,
    input  logic            car,
`ifdef ACCESS_PROG_EN
    input  logic            prog,
`endif
    output logic            canc,
    output logic [2:0]      rgb,
    output logic [2:0]      state,
    output logic [3:0]      digits,
    output logic [2:0]      tries_left
);

    localparam int KW = CODE_LEN * SYM_W;
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int TW = 16;

    state_t          st;
    state_t          nxt;
    logic [NBTN-1:0] pulse;
    logic            press_any;
    logic [SYM_W-1:0] sym;
    logic [KW-1:0]   code_in;
    logic [KW-1:0]   code_q;
    logic [KW-1:0]   code_sh;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   tlim;
    logic            tick;
    logic            tdone;
    logic            take;
    logic            commit;
    logic            restart;
    logic            match;
    logic            blink;

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clock (clock),
            .reset (reset),
            .bot   (bot[g]),
            .press (pulse[g])
        );
    end

    // lowest index wins when several pulses coincide
    always_comb begin
        press_any = 1'b0;
        sym       = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (pulse[i]) begin
                press_any = 1'b1;
                sym       = SYM_W'(i);
            end
        end
    end

    // first symbol entered ends up in the LSBs after CODE_LEN shifts
    assign code_sh = {sym, code_in[KW-1:SYM_W]};
    assign match   = (code_in == code_q);
    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign tdone   = tick && (tcnt == tlim - 1'b1);

    always_comb begin
        tlim = TW'(ENTRY_TO);
        case (st)
            GRANTED: tlim = TW'(OPEN_T);
            DENIED:  tlim = TW'(DENY_T);
            LOCK:    tlim = TW'(LOCK_T);
            default: tlim = TW'(ENTRY_TO);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) st <= IDLE;
        else       st <= nxt;
    end

    always_comb begin
        nxt    = st;
        take   = 1'b0;
        commit = 1'b0;
        case (st)
            IDLE: begin
                if (press_any && car) begin
                    nxt  = ENTRY;
                    take = 1'b1;
                end
            end
            ENTRY: begin
                if (!car || tdone) begin
                    nxt = IDLE;
                end else if (press_any) begin
                    take = 1'b1;
                    if (digits == 4'(CODE_LEN - 1)) nxt = CHECK;
                end
            end
            CHECK: begin
                if (match)                nxt = GRANTED;
                else if (tries_left <= 1) nxt = LOCK;
                else                      nxt = DENIED;
            end
            GRANTED: begin
                if (tdone) nxt = IDLE;
`ifdef ACCESS_PROG_EN
                if (prog) nxt = PROG;
`endif
            end
            DENIED:  if (tdone) nxt = IDLE;
            LOCK:    if (tdone) nxt = IDLE;
`ifdef ACCESS_PROG_EN
            PROG: begin
                if (tdone) begin
                    nxt = IDLE;
                end else if (press_any) begin
                    take = 1'b1;
                    if (digits == 4'(CODE_LEN - 1)) begin
                        nxt    = IDLE;
                        commit = 1'b1;
                    end
                end
            end
`endif
            default: nxt = IDLE;
        endcase
        restart = (nxt != st) || take;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digits     <= '0;
            tries_left <= 3'(MAX_TRIES);
            code_in    <= '0;
            presc      <= '0;
            tcnt       <= '0;
            blink      <= 1'b1;
        end else begin
            if (restart) begin
                presc <= '0;
                tcnt  <= '0;
            end else if (tick) begin
                presc <= '0;
                tcnt  <= tcnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (nxt != st)  blink <= 1'b1;
            else if (tick)  blink <= ~blink;
            if (take) begin
                code_in <= code_sh;
                digits  <= digits + 1'b1;
            end
            if (nxt == IDLE || st == CHECK) digits <= '0;
            if (st == CHECK) begin
                if (match)                 tries_left <= 3'(MAX_TRIES);
                else if (tries_left != '0) tries_left <= tries_left - 1'b1;
            end
            if (st == LOCK && nxt == IDLE) tries_left <= 3'(MAX_TRIES);
        end
    end

`ifdef ACCESS_PROG_EN
    // the entry register doubles as the programming shadow
    always_ff @(posedge clock) begin
        if (reset)       code_q <= DEFAULT_CODE;
        else if (commit) code_q <= code_sh;
    end
`else
    assign code_q = DEFAULT_CODE;
`endif

    assign canc  = (st == GRANTED);
    assign state = st;
    assign rgb   = state_rgb(st, blink);

endmodule

// File: tb/tb_access_ctrl_n.sv
// Directed self-checking bench for access_ctrl_n with short timer settings.
// Build with +define+ACCESS_PROG_EN to also exercise reprogramming.
module tb_access_ctrl_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] bot   = 4'hF;
    logic       car   = 1'b0;
`ifdef ACCESS_PROG_EN
    logic       prog  = 1'b0;
`endif
    logic       canc;
    logic [2:0] rgb;
    logic [2:0] state;
    logic [3:0] digits;
    logic [2:0] tries_left;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    access_ctrl_n #(
        .TICK_DIV   (4),
        .DEB_CYCLES (2),
        .OPEN_T     (3),
        .DENY_T     (2),
        .LOCK_T     (4),
        .ENTRY_TO   (5),
        .MAX_TRIES  (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bot        (bot),
        .car        (car),
`ifdef ACCESS_PROG_EN
        .prog       (prog),
`endif
        .canc       (canc),
        .rgb        (rgb),
        .state      (state),
        .digits     (digits),
        .tries_left (tries_left)
    );

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int b);
        @(negedge clock);
        bot[b] = 1'b0;
        wait_n(6);
        bot[b] = 1'b1;
        wait_n(6);
    endtask

    // drive the final press and stop right after the pulse's 6th edge
    task automatic last_press(input int b);
        @(negedge clock);
        bot[b] = 1'b0;
        wait_n(6);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        bot   = 4'hF;
        wait_n(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++;
        if (state !== 3'd0 || canc !== 1'b0 || rgb !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_out: st=%0d canc=%0d rgb=%b want 0 0 001",
                     state, canc, rgb);
        end
        n_tests++;
        if (digits !== 4'd0 || tries_left !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_cnt: digits=%0d tries=%0d want 0 3",
                     digits, tries_left);
        end
    endtask

    task automatic test_correct;
        int hi;
        car = 1'b1;
        for (int i = 0; i < 3; i++) begin
            press(i);
            n_tests++;
            if (digits !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL digits_%0d: got %0d want %0d", i, digits, i + 1);
            end
        end
        @(negedge clock);
        bot[3] = 1'b0;
        wait_n(5);
        n_tests++;
        if (canc !== 1'b0 || state !== 3'd2 || digits !== 4'd4) begin
            n_fail++;
            $display("FAIL check_cycle: canc=%0d st=%0d dg=%0d want 0 2 4",
                     canc, state, digits);
        end
        wait_n(1);
        bot[3] = 1'b1;
        n_tests++;
        if (canc !== 1'b1 || rgb !== 3'b010) begin
            n_fail++;
            $display("FAIL granted: canc=%0d rgb=%b want 1 010", canc, rgb);
        end
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (canc) hi++;
            @(negedge clock);
        end
        n_tests++;
        if (hi !== 12 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL open_len: cycles=%0d st=%0d want 12 0", hi, state);
        end
    endtask

    task automatic test_wrong;
        int red;
        int opened;
        for (int i = 0; i < 3; i++) press(0);
        last_press(0);
        bot[0] = 1'b1;
        n_tests++;
        if (state !== 3'd4 || tries_left !== 3'd2) begin
            n_fail++;
            $display("FAIL denied: st=%0d tries=%0d want 4 2", state, tries_left);
        end
        red = 0;
        opened = 0;
        for (int k = 0; k < 12; k++) begin
            if (rgb == 3'b100) red++;
            if (canc) opened++;
            @(negedge clock);
        end
        n_tests++;
        if (red !== 8 || opened !== 0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL deny_len: red=%0d open=%0d st=%0d want 8 0 0",
                     red, opened, state);
        end
    endtask

    task automatic test_lockout;
        do_reset();
        car = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) press(1);
            wait_n(6);
        end
        n_tests++;
        if (tries_left !== 3'd1 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL pre_lock: tries=%0d st=%0d want 1 0", tries_left, state);
        end
        for (int i = 0; i < 3; i++) press(1);
        last_press(1);
        bot[1] = 1'b1;
        bot[0] = 1'b0;
        n_tests++;
        if (state !== 3'd5 || rgb !== 3'b100 || tries_left !== 3'd0) begin
            n_fail++;
            $display("FAIL lock_in: st=%0d rgb=%b tries=%0d want 5 100 0",
                     state, rgb, tries_left);
        end
        wait_n(4);
        n_tests++;
        if (rgb !== 3'b000) begin
            n_fail++;
            $display("FAIL lock_dark: rgb=%b want 000", rgb);
        end
        wait_n(2);
        bot[0] = 1'b1;
        n_tests++;
        if (digits !== 4'd0 || state !== 3'd5) begin
            n_fail++;
            $display("FAIL lock_ignore: dg=%0d st=%0d want 0 5", digits, state);
        end
        wait_n(2);
        n_tests++;
        if (rgb !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_relit: rgb=%b want 100", rgb);
        end
        wait_n(7);
        n_tests++;
        if (state !== 3'd5) begin
            n_fail++;
            $display("FAIL lock_end_early: st=%0d want 5", state);
        end
        wait_n(1);
        n_tests++;
        if (state !== 3'd0 || tries_left !== 3'd3 || digits !== 4'd0) begin
            n_fail++;
            $display("FAIL lock_out: st=%0d tries=%0d dg=%0d want 0 3 0",
                     state, tries_left, digits);
        end
        wait_n(6);
    endtask

    task automatic test_bounce_simul;
        @(negedge clock);
        bot[2] = 1'b0;
        @(negedge clock);
        bot[2] = 1'b1;
        wait_n(8);
        n_tests++;
        if (digits !== 4'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch: dg=%0d st=%0d want 0 0", digits, state);
        end
        press(0);
        @(negedge clock);
        bot = 4'b1001;
        wait_n(6);
        bot = 4'hF;
        wait_n(6);
        n_tests++;
        if (digits !== 4'd2) begin
            n_fail++;
            $display("FAIL simul_count: dg=%0d want 2", digits);
        end
        press(2);
        last_press(3);
        bot[3] = 1'b1;
        n_tests++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL simul_sym: st=%0d want 3", state);
        end
        wait_n(20);
    endtask

    task automatic test_timeout;
        press(0);
        press(1);
        n_tests++;
        if (digits !== 4'd2 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL to_entry: dg=%0d st=%0d want 2 1", digits, state);
        end
        wait_n(12);
        n_tests++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL to_early: st=%0d want 1", state);
        end
        wait_n(1);
        n_tests++;
        if (state !== 3'd0 || digits !== 4'd0 || tries_left !== 3'd3) begin
            n_fail++;
            $display("FAIL to_expire: st=%0d dg=%0d tries=%0d want 0 0 3",
                     state, digits, tries_left);
        end
        press(0);
        press(1);
        @(negedge clock);
        car = 1'b0;
        wait_n(1);
        n_tests++;
        if (state !== 3'd0 || digits !== 4'd0 || tries_left !== 3'd3) begin
            n_fail++;
            $display("FAIL car_loss: st=%0d dg=%0d tries=%0d want 0 0 3",
                     state, digits, tries_left);
        end
        press(0);
        n_tests++;
        if (state !== 3'd0 || digits !== 4'd0) begin
            n_fail++;
            $display("FAIL no_car: st=%0d dg=%0d want 0 0", state, digits);
        end
        car = 1'b1;
    endtask

    task automatic test_reset_granted;
        for (int i = 0; i < 3; i++) press(i);
        last_press(3);
        bot[3] = 1'b1;
        n_tests++;
        if (canc !== 1'b1) begin
            n_fail++;
            $display("FAIL rg_open: canc=%0d want 1", canc);
        end
        wait_n(2);
        reset = 1'b1;
        wait_n(1);
        n_tests++;
        if (canc !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL rg_abort: canc=%0d st=%0d want 0 0", canc, state);
        end
        reset = 1'b0;
        wait_n(2);
    endtask

`ifdef ACCESS_PROG_EN
    task automatic test_prog;
        for (int i = 0; i < 3; i++) press(i);
        prog = 1'b1;
        last_press(3);
        bot[3] = 1'b1;
        wait_n(1);
        n_tests++;
        if (state !== 3'd6 || canc !== 1'b0 || rgb !== 3'b111) begin
            n_fail++;
            $display("FAIL prog_enter: st=%0d canc=%0d rgb=%b want 6 0 111",
                     state, canc, rgb);
        end
        prog = 1'b0;
        for (int i = 0; i < 3; i++) press(3);
        @(negedge clock);
        bot[3] = 1'b0;
        wait_n(5);
        bot[3] = 1'b1;
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL prog_done: st=%0d want 0", state);
        end
        wait_n(6);
        for (int i = 0; i < 3; i++) press(i);
        last_press(3);
        bot[3] = 1'b1;
        n_tests++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL prog_old: st=%0d want 4", state);
        end
        wait_n(10);
        for (int i = 0; i < 3; i++) press(3);
        last_press(3);
        bot[3] = 1'b1;
        n_tests++;
        if (state !== 3'd3 || canc !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_new: st=%0d canc=%0d want 3 1", state, canc);
        end
        wait_n(20);
    endtask
`endif

    initial begin
        test_reset();
        test_correct();
        test_wrong();
        test_lockout();
        test_bounce_simul();
        test_timeout();
        test_reset_granted();
`ifdef ACCESS_PROG_EN
        test_prog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
